// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the boot/monitor ROM read arbiter.
// Latency constants match the two ROM output-register options.
package rom_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef logic owner_t;

    localparam int LAT_NOREG  = 1;
    localparam int LAT_OUTREG = 2;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational grant, registered last_grant.
// Intended for reuse by other shared-memory controllers.
module rr_arbiter_2
    import rom_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o,
    output owner_t     winner_o
);

    owner_t last_q;
    owner_t winner_d;

    // Contention goes to the port that did not win last; grant is empty with no valid.
    always_comb begin
        winner_d = ~last_q;
        case (valid_i)
            2'b01:   winner_d = 1'b0;
            2'b10:   winner_d = 1'b1;
            default: winner_d = ~last_q;
        endcase
        grant_o           = 2'b00;
        grant_o[winner_d] = valid_i[winner_d];
    end

    assign winner_o = winner_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (accept_i) begin
            last_q <= winner_d;
        end
    end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one single-port synchronous ROM between two read requesters,
// one read in flight, with ROM read latency of 1 or 2 clocks.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 15,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_rvalid,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_rvalid,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  busy
);

    if (ROM_LATENCY != LAT_NOREG && ROM_LATENCY != LAT_OUTREG) begin : g_bad_latency
        $error("rom_read_arbiter: ROM_LATENCY must be 1 or 2");
    end

    localparam logic [1:0] LAT_CNT = 2'(ROM_LATENCY);

    state_t                state_q;
    logic [1:0]            cnt_q;
    owner_t                owner_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;
    logic                  rvalid0_q;
    logic                  rvalid1_q;

    logic [1:0]            grant;
    owner_t                winner;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] win_addr_d;

    rr_arbiter_2 u_arb (
        .clock    (clock),
        .reset_n  (reset_n),
        .valid_i  ({req1_valid, req0_valid}),
        .accept_i (accept),
        .grant_o  (grant),
        .winner_o (winner)
    );

    assign req0_ready = (state_q == IDLE) && grant[0];
    assign req1_ready = (state_q == IDLE) && grant[1];
    assign accept     = req0_ready || req1_ready;
    assign win_addr_d = winner ? req1_addr : req0_addr;

    // cnt counts down the ROM latency; capture happens on the edge after it hits zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            owner_q    <= 1'b0;
            rom_addr_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rom_addr_q <= win_addr_d;
                        owner_q    <= winner;
                        cnt_q      <= LAT_CNT;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        if (owner_q == 1'b0) begin
                            rdata0_q  <= rom_data;
                            rvalid0_q <= 1'b1;
                        end else begin
                            rdata1_q  <= rom_data;
                            rvalid1_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign rom_address = rom_addr_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign busy        = (state_q == WAIT);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: cycle table for latency 1 plus hand
// sequences for latency 2, reset mid-read and hold-while-busy.
module tb_rom_read_arbiter;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // latency-1 instance
    logic        v0, v1, r0, r1, rv0, rv1, busy1;
    logic [14:0] a0, a1, ra1;
    logic [7:0]  d0, d1, rom_d1;

    // latency-2 instance
    logic        v0_2, v1_2, r0_2, r1_2, rv0_2, rv1_2, busy2;
    logic [14:0] a0_2, a1_2, ra2;
    logic [7:0]  d0_2, d1_2, rom_d2, rom_s2;

    rom_read_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .ROM_LATENCY(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(v0), .req0_addr(a0), .req0_ready(r0), .req0_rdata(d0), .req0_rvalid(rv0),
        .req1_valid(v1), .req1_addr(a1), .req1_ready(r1), .req1_rdata(d1), .req1_rvalid(rv1),
        .rom_address(ra1), .rom_data(rom_d1), .busy(busy1)
    );

    rom_read_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(8), .ROM_LATENCY(2)) dut2 (
        .clock(clock), .reset_n(reset_n),
        .req0_valid(v0_2), .req0_addr(a0_2), .req0_ready(r0_2), .req0_rdata(d0_2), .req0_rvalid(rv0_2),
        .req1_valid(v1_2), .req1_addr(a1_2), .req1_ready(r1_2), .req1_rdata(d1_2), .req1_rvalid(rv1_2),
        .rom_address(ra2), .rom_data(rom_d2), .busy(busy2)
    );

    function automatic logic [7:0] rom_f(input logic [14:0] a);
        case (a)
            15'h0000: rom_f = 8'hC3;
            15'h7FFF: rom_f = 8'h5A;
            15'h0010: rom_f = 8'h11;
            15'h0020: rom_f = 8'h22;
            15'h0040: rom_f = 8'h4C;
            15'h0100: rom_f = 8'hA0;
            15'h0101: rom_f = 8'hA1;
            15'h0102: rom_f = 8'hA2;
            default:  rom_f = 8'hEE;
        endcase
    endfunction

    // ROM models: no output register, and one output register
    always @(posedge clock) begin
        rom_d1 <= rom_f(ra1);
        rom_s2 <= rom_f(ra2);
        rom_d2 <= rom_s2;
    end

    // requester protocol: a pending valid must be held until ready
    logic hold0 = 1'b0, hold1 = 1'b0;
    always @(posedge clock) begin
        if (!reset_n) begin
            hold0 <= 1'b0;
            hold1 <= 1'b0;
        end else begin
            if ((hold0 && !v0) || (hold1 && !v1)) begin
                errors++;
                $display("FAIL protocol: valid dropped before accept (v0=%0b v1=%0b)", v0, v1);
            end
            hold0 <= v0 && !r0;
            hold1 <= v1 && !r1;
        end
    end

    always @(negedge clock) begin
        if ((r0 && r1) || (r0_2 && r1_2)) begin
            errors++;
            $display("FAIL both_ready: dut1 %0b%0b dut2 %0b%0b, required never both", r0, r1, r0_2, r1_2);
        end
        if ((busy1 && (r0 || r1)) || (busy2 && (r0_2 || r1_2))) begin
            errors++;
            $display("FAIL ready_in_wait: ready high while busy");
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        v0;
        logic [14:0] a0;
        logic        v1;
        logic [14:0] a1;
        logic        r0, r1, rv0, rv1;
        logic [7:0]  d0, d1;
        logic        busy;
        logic [14:0] ra;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic iv0, input logic [14:0] ia0,
                                input logic iv1, input logic [14:0] ia1,
                                input logic er0, input logic er1, input logic erv0, input logic erv1,
                                input logic [7:0] ed0, input logic [7:0] ed1,
                                input logic ebusy, input logic [14:0] era);
        vec_t t;
        t.rst = rst; t.v0 = iv0; t.a0 = ia0; t.v1 = iv1; t.a1 = ia1;
        t.r0 = er0; t.r1 = er1; t.rv0 = erv0; t.rv1 = erv1;
        t.d0 = ed0; t.d1 = ed1; t.busy = ebusy; t.ra = era;
        return t;
    endfunction

    vec_t tbl[31];
    int   busy_cnt;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        v0 = 0; v1 = 0; a0 = '0; a1 = '0;
        v0_2 = 0; v1_2 = 0; a0_2 = '0; a1_2 = '0;

        //             rst v0 a0       v1 a1      r0 r1 rv0 rv1 d0     d1     bsy ra
        tbl[0]  = mk(1, 0, 15'h000, 0, 15'h000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 15'h000);
        // single read, latency 1
        tbl[1]  = mk(0, 1, 15'h000, 0, 15'h000, 1, 0, 0, 0, 8'h00, 8'h00, 0, 15'h000);
        tbl[2]  = mk(0, 0, 15'h000, 0, 15'h000, 0, 0, 0, 0, 8'h00, 8'h00, 1, 15'h000);
        tbl[3]  = mk(0, 0, 15'h000, 0, 15'h000, 0, 0, 0, 0, 8'h00, 8'h00, 1, 15'h000);
        tbl[4]  = mk(0, 0, 15'h000, 0, 15'h000, 0, 0, 1, 0, 8'hC3, 8'h00, 0, 15'h000);
        tbl[5]  = mk(0, 0, 15'h000, 0, 15'h000, 0, 0, 0, 0, 8'hC3, 8'h00, 0, 15'h000);
        // contention from reset: grants 0,1,0,1
        tbl[6]  = mk(1, 0, 15'h000, 0, 15'h000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 15'h000);
        tbl[7]  = mk(0, 1, 15'h010, 1, 15'h020, 1, 0, 0, 0, 8'h00, 8'h00, 0, 15'h000);
        tbl[8]  = mk(0, 0, 15'h010, 1, 15'h020, 0, 0, 0, 0, 8'h00, 8'h00, 1, 15'h010);
        tbl[9]  = mk(0, 0, 15'h010, 1, 15'h020, 0, 0, 0, 0, 8'h00, 8'h00, 1, 15'h010);
        tbl[10] = mk(0, 1, 15'h010, 1, 15'h020, 0, 1, 1, 0, 8'h11, 8'h00, 0, 15'h010);
        tbl[11] = mk(0, 1, 15'h010, 0, 15'h020, 0, 0, 0, 0, 8'h11, 8'h00, 1, 15'h020);
        tbl[12] = mk(0, 1, 15'h010, 0, 15'h020, 0, 0, 0, 0, 8'h11, 8'h00, 1, 15'h020);
        tbl[13] = mk(0, 1, 15'h010, 1, 15'h020, 1, 0, 0, 1, 8'h11, 8'h22, 0, 15'h020);
        tbl[14] = mk(0, 0, 15'h010, 1, 15'h020, 0, 0, 0, 0, 8'h11, 8'h22, 1, 15'h010);
        tbl[15] = mk(0, 0, 15'h010, 1, 15'h020, 0, 0, 0, 0, 8'h11, 8'h22, 1, 15'h010);
        tbl[16] = mk(0, 0, 15'h010, 1, 15'h020, 0, 1, 1, 0, 8'h11, 8'h22, 0, 15'h010);
        tbl[17] = mk(0, 0, 15'h010, 0, 15'h020, 0, 0, 0, 0, 8'h11, 8'h22, 1, 15'h020);
        tbl[18] = mk(0, 0, 15'h010, 0, 15'h020, 0, 0, 0, 0, 8'h11, 8'h22, 1, 15'h020);
        tbl[19] = mk(0, 0, 15'h010, 0, 15'h020, 0, 0, 0, 1, 8'h11, 8'h22, 0, 15'h020);
        // back-to-back port 0 reads, one per 3 clocks
        tbl[20] = mk(0, 1, 15'h100, 0, 15'h000, 1, 0, 0, 0, 8'h11, 8'h22, 0, 15'h020);
        tbl[21] = mk(0, 1, 15'h101, 0, 15'h000, 0, 0, 0, 0, 8'h11, 8'h22, 1, 15'h100);
        tbl[22] = mk(0, 1, 15'h101, 0, 15'h000, 0, 0, 0, 0, 8'h11, 8'h22, 1, 15'h100);
        tbl[23] = mk(0, 1, 15'h101, 0, 15'h000, 1, 0, 1, 0, 8'hA0, 8'h22, 0, 15'h100);
        tbl[24] = mk(0, 1, 15'h102, 0, 15'h000, 0, 0, 0, 0, 8'hA0, 8'h22, 1, 15'h101);
        tbl[25] = mk(0, 1, 15'h102, 0, 15'h000, 0, 0, 0, 0, 8'hA0, 8'h22, 1, 15'h101);
        tbl[26] = mk(0, 1, 15'h102, 0, 15'h000, 1, 0, 1, 0, 8'hA1, 8'h22, 0, 15'h101);
        tbl[27] = mk(0, 0, 15'h102, 0, 15'h000, 0, 0, 0, 0, 8'hA1, 8'h22, 1, 15'h102);
        tbl[28] = mk(0, 0, 15'h102, 0, 15'h000, 0, 0, 0, 0, 8'hA1, 8'h22, 1, 15'h102);
        tbl[29] = mk(0, 0, 15'h102, 0, 15'h000, 0, 0, 1, 0, 8'hA2, 8'h22, 0, 15'h102);
        tbl[30] = mk(0, 0, 15'h102, 0, 15'h000, 0, 0, 0, 0, 8'hA2, 8'h22, 0, 15'h102);

        to_drive();
        for (int i = 0; i < 31; i++) begin
            reset_n = ~tbl[i].rst;
            v0 = tbl[i].v0; a0 = tbl[i].a0;
            v1 = tbl[i].v1; a1 = tbl[i].a1;
            @(negedge clock);
            chk($sformatf("v%0d.ready0", i), r0, tbl[i].r0);
            chk($sformatf("v%0d.ready1", i), r1, tbl[i].r1);
            chk($sformatf("v%0d.rvalid0", i), rv0, tbl[i].rv0);
            chk($sformatf("v%0d.rvalid1", i), rv1, tbl[i].rv1);
            chk($sformatf("v%0d.rdata0", i), d0, tbl[i].d0);
            chk($sformatf("v%0d.rdata1", i), d1, tbl[i].d1);
            chk($sformatf("v%0d.busy", i), busy1, tbl[i].busy);
            chk($sformatf("v%0d.rom_address", i), ra1, tbl[i].ra);
            to_drive();
        end

        // latency 2, top address on port 1
        v1_2 = 1; a1_2 = 15'h7FFF;
        @(negedge clock);
        chk("lat2.ready1", r1_2, 1'b1);
        to_drive();
        v1_2 = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            busy_cnt += int'(busy2);
            chk($sformatf("lat2.rvalid1_c%0d", k), rv1_2, (k == 4));
            chk($sformatf("lat2.rvalid0_c%0d", k), rv0_2, 1'b0);
            if (k == 1) chk("lat2.rom_address", ra2, 15'h7FFF);
            if (k == 4) chk("lat2.rdata1", d1_2, 8'h5A);
            to_drive();
        end
        chk("lat2.busy_cycles", busy_cnt, 3);

        // reset mid-read
        v0 = 1; a0 = 15'h040;
        @(negedge clock);
        chk("rst.ready0", r0, 1'b1);
        to_drive();
        v0 = 0;
        @(negedge clock);
        chk("rst.busy_before", busy1, 1'b1);
        chk("rst.rom_addr_before", ra1, 15'h040);
        #2 reset_n = 0;
        #1;
        chk("rst.rom_address", ra1, 15'h000);
        chk("rst.busy", busy1, 1'b0);
        chk("rst.rvalid0", rv0, 1'b0);
        chk("rst.rdata0", d0, 8'h00);
        @(posedge clock);
        #3 reset_n = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("rst.no_stray_c%0d", k), {rv0, rv1, busy1}, 3'b000);
        end
        to_drive();
        v0 = 1; a0 = 15'h040;
        @(negedge clock);
        chk("rst.after_ready0", r0, 1'b1);
        to_drive();
        v0 = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk($sformatf("rst.after_rvalid0_c%0d", k), rv0, (k == 3));
            if (k == 3) chk("rst.after_rdata0", d0, 8'h4C);
            to_drive();
        end

        // port 1 held off while port 0 is in flight
        v0 = 1; a0 = 15'h010;
        @(negedge clock);
        chk("hold.ready0", r0, 1'b1);
        to_drive();
        v0 = 0; v1 = 1; a1 = 15'h020;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            chk($sformatf("hold.ready1_wait_c%0d", k), r1, 1'b0);
            to_drive();
        end
        @(negedge clock);
        chk("hold.rvalid0", rv0, 1'b1);
        chk("hold.rdata0", d0, 8'h11);
        chk("hold.ready1_idle", r1, 1'b1);
        to_drive();
        v1 = 0;
        for (int k = 4; k <= 6; k++) begin
            @(negedge clock);
            chk($sformatf("hold.rdata0_c%0d", k), d0, 8'h11);
            chk($sformatf("hold.rvalid1_c%0d", k), rv1, (k == 6));
            if (k == 6) chk("hold.rdata1", d1, 8'h22);
            to_drive();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
